// File: rtl/pwm_pkg.sv
// Shared servo PWM definitions: FSM encoding, default timing and datapath widths.
package pwm_pkg;

   // Default timing at 50 MHz: 1 ms -> 0 deg, 2 ms -> full range, 40 ms silence limit.
   localparam int unsigned DEF_MIN_PULSE_CYC = 50_000;
   localparam int unsigned DEF_MAX_PULSE_CYC = 100_000;
   localparam int unsigned DEF_MAX_RANGE     = 180;
   localparam int unsigned DEF_TIMEOUT_CYC   = 2_000_000;

   // Numerator, counter, divisor and angle widths.
   localparam int unsigned NUM_W    = 24;
   localparam int unsigned CNT_W    = 21;
   localparam int unsigned DIV_W    = 17;
   localparam int unsigned DEG_W    = 8;
   localparam int unsigned DIV_ITER = NUM_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_CALC = 2'd2,
      ST_LOW  = 2'd3
   } pwm_state_e;

   // One decoded frame as presented to the consumer.
   typedef struct packed {
      logic [DEG_W-1:0] degrees;
      logic [CNT_W-1:0] pulse_width;
      logic             range_err;
   } pwm_result_t;

endpackage

// File: rtl/servo_pwm_decoder_if.sv
// Servo PWM line in, decoded angle/status out.
interface servo_pwm_decoder_if;
   import pwm_pkg::*;

   logic             pwm_in;
   logic [DEG_W-1:0] degrees;
   logic [CNT_W-1:0] pulse_width;
   logic             valid;
   logic             range_err;
   logic             timeout;

   // Decoder side.
   modport master (
      input  pwm_in,
      output degrees, pulse_width, valid, range_err, timeout
   );

   // Line driver / result consumer side.
   modport slave (
      output pwm_in,
      input  degrees, pulse_width, valid, range_err, timeout
   );
endinterface

// File: rtl/pwm_serial_div.sv
// Serial restoring divider, one quotient bit per cycle, done 24 cycles after start.
module pwm_serial_div
   import pwm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NUM_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic [DEG_W-1:0] quotient,
   output logic             done
);
   localparam int unsigned IT_W = $clog2(DIV_ITER + 1);

   logic [DIV_W-1:0] rem_q;
   logic [DIV_W-1:0] dsr_q;
   logic [NUM_W-1:0] acc_q;
   logic [IT_W-1:0]  cnt_q;
   logic             busy_q;
   logic             done_q;

   logic [DIV_W-1:0] rem_src_c;
   logic [NUM_W-1:0] acc_src_c;
   logic [DIV_W-1:0] dsr_src_c;
   logic [DIV_W:0]   trial_c;
   logic [DIV_W-1:0] rem_nxt_c;
   logic [NUM_W-1:0] acc_nxt_c;
   logic             qbit_c;

   // One restoring step; on start the first step runs straight off the inputs.
   always_comb begin
      rem_src_c = start ? '0 : rem_q;
      acc_src_c = start ? dividend : acc_q;
      dsr_src_c = start ? divisor : dsr_q;
      trial_c   = {rem_src_c, acc_src_c[NUM_W-1]};
      qbit_c    = 1'b0;
      rem_nxt_c = trial_c[DIV_W-1:0];
      if (trial_c >= {1'b0, dsr_src_c}) begin
         qbit_c    = 1'b1;
         rem_nxt_c = DIV_W'(trial_c - {1'b0, dsr_src_c});
      end
      acc_nxt_c = {acc_src_c[NUM_W-2:0], qbit_c};
   end

   // Iteration state; acc shifts the dividend out and the quotient in.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         dsr_q  <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            rem_q  <= rem_nxt_c;
            acc_q  <= acc_nxt_c;
            dsr_q  <= divisor;
            cnt_q  <= IT_W'(1);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            rem_q <= rem_nxt_c;
            acc_q <= acc_nxt_c;
            cnt_q <= cnt_q + IT_W'(1);
            if (cnt_q == IT_W'(DIV_ITER - 1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign quotient = acc_q[DEG_W-1:0];
   assign done     = done_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high time and converts it to an angle in degrees.
module servo_pwm_decoder
   import pwm_pkg::*;
#(
   parameter int unsigned MIN_PULSE_CYC = DEF_MIN_PULSE_CYC,
   parameter int unsigned MAX_PULSE_CYC = DEF_MAX_PULSE_CYC,
   parameter int unsigned MAX_RANGE     = DEF_MAX_RANGE,
   parameter int unsigned TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
   input  logic                clk,
   input  logic                rst,
   servo_pwm_decoder_if.master bus
);
   localparam int unsigned DEN = MAX_PULSE_CYC - MIN_PULSE_CYC;

   logic [1:0]       sync_q;
   logic             s_prev_q;
   logic             s_in;
   logic             rise_c;
   logic             fall_c;

   pwm_state_e       state_q;
   pwm_state_e       state_d;
   logic             start_c;
   logic             capture_c;
   logic             tmo_c;
   logic             accept_c;
   logic             tmo_hit_c;

   logic [CNT_W-1:0] width_q;
   logic [CNT_W-1:0] period_q;
   logic             range_lo_q;
   logic             range_hi_q;
   logic             lo_c;
   logic             hi_c;
   logic [NUM_W-1:0] num_c;

   logic [DEG_W-1:0] div_q;
   logic             div_done;

   pwm_result_t      result_q;
   logic             valid_q;
   logic             timeout_q;

   // Two-flop synchronizer plus edge history; preset high so a line already high is not an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= 2'b11;
         s_prev_q <= 1'b1;
      end else begin
         sync_q   <= {sync_q[0], bus.pwm_in};
         s_prev_q <= sync_q[1];
      end
   end

   assign s_in      = sync_q[1];
   assign rise_c    = s_in & ~s_prev_q;
   assign fall_c    = ~s_in & s_prev_q;
   assign tmo_hit_c = (period_q >= CNT_W'(TIMEOUT_CYC));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state and datapath strobes; rising edges in CALC are deliberately ignored.
   always_comb begin
      state_d   = state_q;
      start_c   = 1'b0;
      capture_c = 1'b0;
      tmo_c     = 1'b0;
      accept_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise_c) begin
               state_d  = ST_HIGH;
               accept_c = 1'b1;
            end
         end
         ST_HIGH: begin
            if (tmo_hit_c) begin
               state_d = ST_IDLE;
               tmo_c   = 1'b1;
            end else if (fall_c) begin
               state_d = ST_CALC;
               start_c = 1'b1;
            end
         end
         ST_CALC: begin
            if (div_done) begin
               state_d   = ST_LOW;
               capture_c = 1'b1;
            end
         end
         ST_LOW: begin
            if (tmo_hit_c) begin
               state_d = ST_IDLE;
               tmo_c   = 1'b1;
            end else if (rise_c) begin
               state_d  = ST_HIGH;
               accept_c = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Range classification and ceiling-rounded numerator for the finished width.
   always_comb begin
      lo_c  = (width_q < CNT_W'(MIN_PULSE_CYC));
      hi_c  = (width_q > CNT_W'(MAX_PULSE_CYC));
      num_c = '0;
      if (!lo_c && !hi_c) begin
         num_c = NUM_W'(width_q - CNT_W'(MIN_PULSE_CYC)) * NUM_W'(MAX_RANGE)
               + NUM_W'(DEN - 1);
      end
   end

   pwm_serial_div u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (start_c),
      .dividend (num_c),
      .divisor  (DIV_W'(DEN)),
      .quotient (div_q),
      .done     (div_done)
   );

   // Width/period counters; the rising-edge cycle itself counts as the first high cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         width_q    <= '0;
         period_q   <= '0;
         range_lo_q <= 1'b0;
         range_hi_q <= 1'b0;
      end else begin
         if (accept_c) begin
            width_q  <= CNT_W'(1);
            period_q <= '0;
         end else begin
            if (state_q == ST_HIGH && s_in) width_q <= width_q + CNT_W'(1);
            if (state_q != ST_IDLE) period_q <= period_q + CNT_W'(1);
         end
         if (start_c) begin
            range_lo_q <= lo_c;
            range_hi_q <= hi_c;
         end
      end
   end

   // Result registers: updated only on a completed division, held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b1;
      end else begin
         valid_q <= capture_c;
         if (capture_c) begin
            result_q.pulse_width <= width_q;
            result_q.range_err   <= range_lo_q | range_hi_q;
            if (range_lo_q)      result_q.degrees <= '0;
            else if (range_hi_q) result_q.degrees <= DEG_W'(MAX_RANGE);
            else                 result_q.degrees <= div_q;
         end
         if (accept_c)   timeout_q <= 1'b0;
         else if (tmo_c) timeout_q <= 1'b1;
      end
   end

   assign bus.degrees     = result_q.degrees;
   assign bus.pulse_width = result_q.pulse_width;
   assign bus.range_err   = result_q.range_err;
   assign bus.valid       = valid_q;
   assign bus.timeout     = timeout_q;

endmodule

// File: doc/servo_pwm_decoder.md
SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

Interface
REQ-001 The block SHALL have parameter MIN_PULSE_CYC, default 50_000, meaning the width in cycles that maps to 0 degrees (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter MAX_PULSE_CYC, default 100_000, meaning the width in cycles that maps to MAX_RANGE.
REQ-003 The block SHALL have parameter MAX_RANGE, default 180, meaning the maximum decoded angle in degrees.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 2_000_000, meaning the longest allowed interval between rising edges, and the longest allowed high time (40 ms).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high (port names below).
REQ-006 clk  input  1  system clock, 50 MHz.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 pwm_in  input  1  asynchronous servo PWM line.
REQ-009 degrees  output  8  last decoded angle, 0..MAX_RANGE.
REQ-010 pulse_width  output  21  last measured high time, in cycles.
REQ-011 valid  output  1  one-cycle strobe; degrees, pulse_width and range_err are updated.
REQ-012 range_err  output  1  qualified by valid; set when the width was outside [MIN_PULSE_CYC, MAX_PULSE_CYC].
REQ-013 timeout  output  1  level signal: no valid PWM activity.

Function
REQ-014 pwm_in SHALL pass through a 2-flop synchronizer; all timing below refers to the second stage (s_in).
REQ-015 FSM states SHALL be IDLE, HIGH, CALC and LOW.
  - IDLE->HIGH: on an s_in rising edge.
  - HIGH->CALC: on an s_in falling edge.
  - CALC->LOW: when the divider signals done.
  - LOW->HIGH: on a rising edge.
REQ-016 The width counter SHALL clear on a rising edge and increment each cycle in HIGH; pulse_width SHALL equal the number of cycles s_in was high.
REQ-017 The period counter SHALL clear on every accepted rising edge and increment in HIGH, CALC and LOW.
REQ-018 Width clamping:
  - w < MIN_PULSE_CYC: degrees = 0, range_err = 1.
  - w > MAX_PULSE_CYC: degrees = MAX_RANGE, range_err = 1.
  - otherwise: degrees = ceil((w-MIN)*MAX_RANGE/(MAX-MIN)), range_err = 0.
  - The ceiling SHALL be computed as (num+den-1)/den, so every generator setting s in 0..180 decodes exactly to s.
REQ-019 The numerator SHALL be 24 bits (the maximum 9_000_000 fits); the division SHALL be a 24-iteration serial restoring division.
REQ-020 Latency: if the falling edge is first seen in s_in at edge t0, valid SHALL be high for exactly one cycle at t0+25; outputs SHALL update on the same edge.
REQ-021 Rising edges during CALC SHALL be ignored (no restart); capture SHALL resume at the next rising edge seen in LOW or IDLE.
REQ-022 If the period counter reaches TIMEOUT_CYC in HIGH or LOW, the block SHALL set timeout = 1 and return to IDLE with no valid.
REQ-023 timeout SHALL clear on the next accepted rising edge.
REQ-024 degrees and pulse_width SHALL hold their last value between valid strobes and across timeouts.

Reset
REQ-025 On rst, the FSM SHALL go to IDLE and outputs SHALL take these values:
  - degrees = 0, pulse_width = 0, valid = 0, range_err = 0.
  - timeout = 1 (no signal yet).
REQ-026 On rst, the synchronizer and edge-history flops SHALL reset to 1, so a line already high at reset release is not counted as a rising edge; the first capture requires a low-then-high transition.
REQ-027 Reset asserted mid-pulse or mid-division SHALL abort with no valid, and the divider SHALL clear.

Structure
REQ-028 A shared package pwm_pkg SHALL hold the FSM state encoding, the default timing constants and the numerator/counter widths (24 and 21); it is shared with the generator side.
REQ-029 The serial divider SHALL be the sub-module pwm_serial_div with this interface:
  - start and done handshake.
  - 24-bit dividend, 17-bit divisor, 8-bit quotient.
  - fixed 24-cycle latency; done pulses for one cycle.

Verification
REQ-030 Reset with pwm_in=1, then pulses high 75_000 / low 925_000 cycles -> no valid for the first partial pulse; subsequent valid with degrees=90, pulse_width=75_000, range_err=0, timeout=0.
REQ-031 Sweep high times floor(50_000*s/180)+50_000 for s=0,1,2,179,180 -> degrees equals s each time.
REQ-032 High 40_000 cycles -> degrees=0, range_err=1. High 120_000 cycles -> degrees=180, range_err=1.
REQ-033 Hold pwm_in low after a valid frame -> timeout rises when the period counter reaches 2_000_000 cycles after the last rising edge; the next rising edge clears it; degrees is unchanged.
REQ-034 Apply a 5-cycle glitch high during CALC, then a normal frame -> no restart; valid at t0+25 with the original width; the next frame decodes normally.
REQ-035 Assert rst 10 cycles into CALC -> no valid; outputs at reset values; the next full frame decodes correctly.
